transaction_engine: RTL and testbench

// Executes one coin transfer between player 1 and player 2 when main control raises start_transaction.

---
 rtl/transaction_engine.sv | 171 +++++++++++++++++
 tb/tb_transaction_engine.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/transaction_engine.sv
// Coin transfer between the two players: read key and both balances from the
// balance RAM, validate, write both new balances back, then run the transfer animation.
module transaction_engine #(
  parameter int unsigned BAL_W        = 8,
  parameter int unsigned KEY_W        = 8,
  parameter logic [23:0] ANIM_TIMEOUT = 24'd12_500_000
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             reset_others,
  input  logic             start_transaction,
  input  logic             player,
  input  logic [BAL_W-1:0] amount,
  input  logic [KEY_W-1:0] key,
  input  logic [BAL_W-1:0] mem_rdata,
  input  logic             anim_done,
  output logic [1:0]       mem_addr,
  output logic [BAL_W-1:0] mem_wdata,
  output logic             mem_we,
  output logic             anim_start,
  output logic             finished_transaction,
  output logic [1:0]       tx_status
);

  typedef enum logic [3:0] {
    IDLE, RD_KEY, CAP_KEY, RD_SRC, CAP_SRC, RD_DST, CAP_DST,
    CHECK, WR_SRC, WR_DST, ANIM, DONE
  } state_t;

  state_t           state_q, state_d;
  logic             player_q, player_d;
  logic [BAL_W-1:0] amount_q, amount_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [KEY_W-1:0] rk_q, rk_d;
  logic [BAL_W-1:0] sb_q, sb_d;
  logic [BAL_W-1:0] db_q, db_d;
  logic [1:0]       addr_q, addr_d;
  logic [1:0]       status_q, status_d;
  logic [23:0]      cnt_q, cnt_d;
  logic [BAL_W:0]   dst_sum;

  // Carry bit of the widened sum flags receiver overflow.
  assign dst_sum   = {1'b0, db_q} + {1'b0, amount_q};
  assign tx_status = status_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= IDLE;
      player_q <= 1'b0;
      amount_q <= '0;
      key_q    <= '0;
      rk_q     <= '0;
      sb_q     <= '0;
      db_q     <= '0;
      addr_q   <= '0;
      status_q <= 2'b00;
      cnt_q    <= '0;
    end else if (!reset_others) begin
      state_q  <= IDLE;
    end else begin
      state_q  <= state_d;
      player_q <= player_d;
      amount_q <= amount_d;
      key_q    <= key_d;
      rk_q     <= rk_d;
      sb_q     <= sb_d;
      db_q     <= db_d;
      addr_q   <= addr_d;
      status_q <= status_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d              = state_q;
    player_d             = player_q;
    amount_d             = amount_q;
    key_d                = key_q;
    rk_d                 = rk_q;
    sb_d                 = sb_q;
    db_d                 = db_q;
    status_d             = status_q;
    cnt_d                = cnt_q;
    mem_addr             = addr_q;
    mem_we               = 1'b0;
    mem_wdata            = '0;
    anim_start           = 1'b0;
    finished_transaction = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_transaction) begin
          player_d = player;
          amount_d = amount;
          key_d    = key;
          state_d  = RD_KEY;
        end
      end
      RD_KEY: begin
        mem_addr = {1'b1, player_q};
        state_d  = CAP_KEY;
      end
      CAP_KEY: begin
        rk_d    = mem_rdata[KEY_W-1:0];
        state_d = RD_SRC;
      end
      RD_SRC: begin
        mem_addr = {1'b0, player_q};
        state_d  = CAP_SRC;
      end
      CAP_SRC: begin
        sb_d    = mem_rdata;
        state_d = RD_DST;
      end
      RD_DST: begin
        mem_addr = {1'b0, ~player_q};
        state_d  = CAP_DST;
      end
      CAP_DST: begin
        db_d    = mem_rdata;
        state_d = CHECK;
      end
      CHECK: begin
        if (key_q != rk_q) begin
          status_d = 2'b01;
          state_d  = DONE;
        end else if (amount_q > sb_q) begin
          status_d = 2'b10;
          state_d  = DONE;
        end else if (dst_sum[BAL_W]) begin
          status_d = 2'b11;
          state_d  = DONE;
        end else begin
          status_d = 2'b00;
          state_d  = (amount_q == '0) ? DONE : WR_SRC;
        end
      end
      WR_SRC: begin
        mem_addr  = {1'b0, player_q};
        mem_we    = 1'b1;
        mem_wdata = sb_q - amount_q;
        state_d   = WR_DST;
      end
      WR_DST: begin
        mem_addr   = {1'b0, ~player_q};
        mem_we     = 1'b1;
        mem_wdata  = dst_sum[BAL_W-1:0];
        anim_start = 1'b1;
        cnt_d      = '0;
        state_d    = ANIM;
      end
      ANIM: begin
        if (anim_done) begin
          state_d = DONE;
        end else if ((ANIM_TIMEOUT != 24'd0) && (cnt_q == ANIM_TIMEOUT - 24'd1)) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      DONE: begin
        finished_transaction = 1'b1;
        if (!start_transaction) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    addr_d = mem_addr;
  end

endmodule

// File: tb/tb_transaction_engine.sv
// Bench for transaction_engine: behavioural RAM, transaction-level outcome model,
// per-cycle output comparison plus literal end-of-transaction expectations.
module tb_transaction_engine;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       reset_others = 1'b1;
  logic       start_transaction = 1'b0;
  logic       player = 1'b0;
  logic [7:0] amount = '0;
  logic [7:0] key = '0;
  logic [7:0] mem_rdata;
  logic       anim_done = 1'b0;
  logic [1:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic       anim_start;
  logic       finished_transaction;
  logic [1:0] tx_status;

  always #5 clock = ~clock;

  transaction_engine #(
    .BAL_W(8),
    .KEY_W(8),
    .ANIM_TIMEOUT(24'd16)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .reset_others(reset_others),
    .start_transaction(start_transaction),
    .player(player),
    .amount(amount),
    .key(key),
    .mem_rdata(mem_rdata),
    .anim_done(anim_done),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we(mem_we),
    .anim_start(anim_start),
    .finished_transaction(finished_transaction),
    .tx_status(tx_status)
  );

  // Balance RAM: synchronous write, registered read.
  logic [7:0] ram [4];
  always @(posedge clock) begin
    if (mem_we === 1'b1) ram[mem_addr] = mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Transaction model: k counts cycles from the first read cycle.
  bit         cmp_en = 1'b0;
  bit         active = 1'b0;
  int         t0 = 0, kdone = 0, kend = 0, abort_k = -1;
  bit         okw = 1'b0;
  logic       p_m = 1'b0;
  logic [7:0] sb_m = '0, db_m = '0, amt_m = '0;
  logic [1:0] st_new = 2'b00, st_prev = 2'b00;
  int         we_cnt = 0, as_cnt = 0;

  int         kc;
  bit         inwin, e_we, e_as, e_fin;
  logic [7:0] e_wd;
  logic [1:0] e_st;

  always @(negedge clock) begin
    if (cmp_en) begin
      kc    = cyc - t0;
      inwin = active && kc >= 0 && !(abort_k >= 0 && kc > abort_k);
      e_we  = inwin && okw && (kc == 7 || kc == 8);
      e_wd  = !e_we ? 8'd0 : (kc == 7 ? 8'(sb_m - amt_m) : 8'(db_m + amt_m));
      e_as  = inwin && okw && kc == 8;
      e_fin = inwin && kc >= kdone && kc <= kend;
      e_st  = (inwin && kc >= 7) ? st_new : st_prev;
      chk("mem_we", mem_we, e_we);
      chk("mem_wdata", mem_wdata, e_wd);
      chk("anim_start", anim_start, e_as);
      chk("finished", finished_transaction, e_fin);
      chk("tx_status", tx_status, e_st);
      if (inwin && (kc == 0 || kc == 1)) chk("addr_rd_key", mem_addr, {1'b1, p_m});
      if (inwin && kc == 2) chk("addr_rd_src", mem_addr, {1'b0, p_m});
      if (inwin && kc == 4) chk("addr_rd_dst", mem_addr, {1'b0, ~p_m});
      if (e_we && kc == 7) chk("addr_wr_src", mem_addr, {1'b0, p_m});
      if (e_we && kc == 8) chk("addr_wr_dst", mem_addr, {1'b0, ~p_m});
      if (mem_we === 1'b1) we_cnt++;
      if (anim_start === 1'b1) as_cnt++;
    end
  end

  // anim_d < 0: no anim_done pulse; ab_k >= 0: reset_others pulsed at that cycle.
  task automatic run_tx(input logic pl, input logic [7:0] am, input logic [7:0] ky,
                        input int anim_d, input int drop_k, input int ab_k,
                        input logic [1:0] lit_st, input int lit_we);
    logic [7:0] rk, sb, db;
    logic [7:0] e [4];
    logic [1:0] st;
    int last;
    rk = ram[{1'b1, pl}];
    sb = ram[{1'b0, pl}];
    db = ram[{1'b0, ~pl}];
    if (ky != rk)                  st = 2'b01;
    else if (am > sb)              st = 2'b10;
    else if (int'(db) + int'(am) > 255) st = 2'b11;
    else                           st = 2'b00;
    for (int i = 0; i < 4; i++) e[i] = ram[i];
    p_m = pl; sb_m = sb; db_m = db; amt_m = am; st_new = st;
    okw = (st == 2'b00) && (am != 0);
    if (okw && ab_k < 0) begin
      e[{1'b0, pl}]  = sb - am;
      e[{1'b0, ~pl}] = db + am;
    end
    kdone   = !okw ? 7 : (anim_d >= 0 ? 10 + anim_d : 9 + 16);
    kend    = (drop_k > kdone) ? drop_k : kdone;
    abort_k = ab_k;
    last    = (ab_k >= 0) ? ab_k + 1 : kend + 1;
    we_cnt  = 0;
    as_cnt  = 0;
    t0      = cyc + 1;
    active  = 1'b1;
    start_transaction = 1'b1;
    player = pl; amount = am; key = ky;
    for (int k = 0; k <= last; k++) begin
      step();
      if (k == 0) begin
        player = ~pl; amount = ~am; key = ~ky;
      end
      anim_done = (anim_d >= 0 && k == 9 + anim_d) || k == 3;
      if (k == drop_k) start_transaction = 1'b0;
      if (ab_k >= 0 && k == ab_k) begin
        reset_others = 1'b0;
        start_transaction = 1'b0;
      end
      if (k == ab_k + 1) reset_others = 1'b1;
    end
    active = 1'b0;
    anim_done = 1'b0;
    if (ab_k < 0) st_prev = st;
    chk("tx_status_lit", tx_status, lit_st);
    chk("we_count", we_cnt, lit_we);
    chk("anim_count", as_cnt, lit_we / 2);
    for (int i = 0; i < 4; i++) chk("ram_model", ram[i], e[i]);
    step();
    step();
  endtask

  initial begin
    ram[0] = 8'd50; ram[1] = 8'd20; ram[2] = 8'h5A; ram[3] = 8'hC3;
    repeat (3) step();
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_anim_start", anim_start, 1'b0);
    chk("rst_finished", finished_transaction, 1'b0);
    chk("rst_tx_status", tx_status, 2'b00);
    chk("rst_mem_addr", mem_addr, 2'b00);
    chk("rst_mem_wdata", mem_wdata, 8'd0);
    resetn = 1'b1;
    cmp_en = 1'b1;
    step();
    step();

    // P1 sends 30 with the right key.
    run_tx(1'b0, 8'd30, 8'h5A, 2, 12, -1, 2'b00, 2);
    chk("t1_p1_bal", ram[0], 8'd20);
    chk("t1_p2_bal", ram[1], 8'd50);

    // Wrong key; start dropped right after launch.
    ram[0] = 8'd50; ram[1] = 8'd20;
    run_tx(1'b0, 8'd30, 8'h5B, -1, 0, -1, 2'b01, 0);

    // P2 short by one coin, then exactly drained.
    ram[0] = 8'd40; ram[1] = 8'd10;
    run_tx(1'b1, 8'd11, 8'hC3, -1, 9, -1, 2'b10, 0);
    run_tx(1'b1, 8'd10, 8'hC3, 0, 10, -1, 2'b00, 2);
    chk("t4_p1_bal", ram[0], 8'd50);
    chk("t4_p2_bal", ram[1], 8'd0);

    // Receiver would overflow.
    ram[0] = 8'd40; ram[1] = 8'd250;
    run_tx(1'b0, 8'd10, 8'hA5 ^ 8'hFF, -1, 7, -1, 2'b11, 0);

    // Soft reset in CAP_SRC: status from the overflow case must survive.
    ram[1] = 8'd20;
    run_tx(1'b0, 8'd5, 8'h5A, -1, 100, 3, 2'b11, 0);
    chk("t6_p1_bal", ram[0], 8'd40);

    // No anim_done: timeout after 16 cycles in ANIM, start held longer.
    run_tx(1'b0, 8'd5, 8'h5A, -1, 30, -1, 2'b00, 2);
    chk("t7_p1_bal", ram[0], 8'd35);
    chk("t7_p2_bal", ram[1], 8'd25);

    // Zero amount with valid key: ok, no writes.
    run_tx(1'b1, 8'd0, 8'hC3, -1, 7, -1, 2'b00, 0);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
